any1_source_release: RTL and testbench



---
 rtl/any1_pkg.sv | 11 +
 rtl/any1_source_release_if.sv | 26 ++
 rtl/any1_prio_enc.sv | 16 +
 rtl/any1_source_release.sv | 71 +++++++
 tb/tb_any1_source_release.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/any1_pkg.sv
// any1_pkg: shared widths, tag type, invalid tag and release FSM states
package any1_pkg;
  localparam int AREGS = 4096;
  localparam int RBIT = 11;
  localparam int RENTRIES = 64;
  localparam int CSLOTS = 4;
  localparam int RIDW = $clog2(RENTRIES);
  typedef logic [RIDW:0] tag_t;
  localparam tag_t TAG_INVALID = '1;
  typedef enum logic [1:0] {IDLE, READ, CMP} state_t;
endpackage

// File: rtl/any1_source_release_if.sv
// any1_source_release_if: commit bundle, source-table read, rename snoop and release write
// master drives bundles, read data and rename writes; slave is the release block
interface any1_source_release_if;
  import any1_pkg::*;
  logic cmt_req;
  logic cmt_rdy;
  logic [CSLOTS-1:0] cmt_v;
  logic [CSLOTS-1:0] cmt_rfw;
  logic [CSLOTS-1:0][RBIT:0] cmt_rd;
  logic [CSLOTS-1:0][RIDW-1:0] cmt_rid;
  logic [RBIT:0] src_ra;
  tag_t src_rd;
  logic ren_we;
  logic [RBIT:0] ren_wa;
  logic rel_we;
  logic [RBIT:0] rel_wa;
  tag_t rel_wd;
  modport master (
    output cmt_req, cmt_v, cmt_rfw, cmt_rd, cmt_rid, src_rd, ren_we, ren_wa,
    input cmt_rdy, src_ra, rel_we, rel_wa, rel_wd
  );
  modport slave (
    input cmt_req, cmt_v, cmt_rfw, cmt_rd, cmt_rid, src_rd, ren_we, ren_wa,
    output cmt_rdy, src_ra, rel_we, rel_wa, rel_wd
  );
endinterface

// File: rtl/any1_prio_enc.sv
// any1_prio_enc: lowest-set-bit finder
// i_req: request vector; o_idx: index of lowest set bit (0 when none); o_any: any bit set
module any1_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int W = $clog2(N);
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) o_idx = i_req[k] ? W'(k) : o_idx;
  end
  assign o_any = |i_req;
endmodule

// File: rtl/any1_source_release.sv
// any1_source_release: on commit, writes the invalid tag back to source-table entries still owned by the committing rid
// clk/rst_n: clock, async active-low reset; i_branchmiss: stall while the table is restored
// bus: commit handshake, table read port, rename snoop, release write port
// o_busy: bundle in progress; o_rel_count: saturating release count
module any1_source_release
  import any1_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_branchmiss,
  any1_source_release_if.slave        bus,
  output logic                        o_busy,
  output logic [15:0]                 o_rel_count
);
  state_t r_state, w_next;
  logic r_up, r_stale, w_acc, w_any, w_ren_hit;
  logic [CSLOTS-1:0] r_mask, w_new_mask, w_clr;
  logic [CSLOTS-1:0][RBIT:0] r_rd;
  logic [CSLOTS-1:0][RIDW-1:0] r_rid;
  logic [$clog2(CSLOTS)-1:0] w_idx;
  logic [RBIT:0] w_rd;
  logic [15:0] r_cnt;
  any1_prio_enc #(.N(CSLOTS)) u_enc (.i_req(r_mask), .o_idx(w_idx), .o_any(w_any));
  assign w_rd = r_rd[w_idx];
  assign w_ren_hit = bus.ren_we && bus.ren_wa == w_rd;
  assign w_clr = r_mask & ~(CSLOTS'(1) << w_idx);
  // r_up keeps cmt_rdy low until the first edge after reset release
  assign bus.cmt_rdy = r_up && r_state == IDLE && !i_branchmiss;
  assign w_acc = bus.cmt_req && bus.cmt_rdy;
  always_comb begin
    w_new_mask = '0;
    for (int k = 0; k < CSLOTS; k++) w_new_mask[k] = bus.cmt_v[k] && bus.cmt_rfw[k] && |bus.cmt_rd[k];
  end
  assign bus.src_ra = r_state == READ ? w_rd : '0;
  // rename writes in READ (stale) or in CMP (w_ren_hit) always beat the release
  assign bus.rel_we = r_state == CMP && w_any && !i_branchmiss && !r_stale && !w_ren_hit
                      && bus.src_rd == {1'b0, r_rid[w_idx]};
  assign bus.rel_wa = r_state == CMP ? w_rd : '0;
  assign bus.rel_wd = TAG_INVALID;
  assign o_busy = r_state != IDLE;
  assign o_rel_count = r_cnt;
  // a branchmiss hitting CMP drops back to READ so the slot is re-read after restore
  always_comb begin
    w_next = r_state;
    if (i_branchmiss) w_next = r_state == CMP ? READ : r_state;
    else if (r_state == IDLE) w_next = w_acc && |w_new_mask ? READ : IDLE;
    else if (r_state == READ) w_next = CMP;
    else w_next = |w_clr ? READ : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_up <= 1'b0;
      r_mask <= '0;
      r_rd <= '0;
      r_rid <= '0;
      r_stale <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_up <= 1'b1;
      r_state <= w_next;
      if (w_acc) begin
        r_mask <= w_new_mask;
        r_rd <= bus.cmt_rd;
        r_rid <= bus.cmt_rid;
      end else if (r_state == CMP && !i_branchmiss) r_mask <= w_clr;
      if (r_state == READ && !i_branchmiss) r_stale <= w_ren_hit;
      if (bus.rel_we && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_any1_source_release.sv
// tb_any1_source_release: directed checks of release, rename override, branchmiss stall and reset
module tb_any1_source_release;
  import any1_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branchmiss = 1'b0;
  logic [15:0] rel_count;
  logic busy;
  logic tb_we = 1'b0;
  logic [RBIT:0] tb_wa = '0;
  tag_t tb_wd = '0;
  tag_t ren_wd = '0;
  tag_t tbl [0:AREGS-1];
  int total = 0;
  int bad = 0;
  any1_source_release_if bus();
  any1_source_release dut (
    .clk(clk), .rst_n(rst_n), .i_branchmiss(branchmiss), .bus(bus),
    .o_busy(busy), .o_rel_count(rel_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.src_rd <= tbl[bus.src_ra];
    if (bus.rel_we) tbl[bus.rel_wa] <= bus.rel_wd;
    if (bus.ren_we) tbl[bus.ren_wa] <= ren_wd;
    if (tb_we) tbl[tb_wa] <= tb_wd;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic setw(input int a, input int d);
    tb_we = 1'b1;
    tb_wa = RBIT'(a);
    tb_wd = tag_t'(d);
    tick();
    tb_we = 1'b0;
  endtask
  task automatic send(input logic [3:0] v, input logic [3:0] rfw,
                      input logic [3:0][11:0] rd, input logic [3:0][5:0] rid);
    bus.cmt_v = v;
    bus.cmt_rfw = rfw;
    bus.cmt_rd = rd;
    bus.cmt_rid = rid;
    bus.cmt_req = 1'b1;
    chk("rdy_before_accept", bus.cmt_rdy, 1);
    tick();
    bus.cmt_req = 1'b0;
    bus.cmt_v = '0;
    bus.cmt_rfw = '0;
    bus.cmt_rd = '0;
    bus.cmt_rid = '0;
  endtask
  initial begin
    bus.cmt_req = 1'b0;
    bus.cmt_v = '0;
    bus.cmt_rfw = '0;
    bus.cmt_rd = '0;
    bus.cmt_rid = '0;
    bus.ren_we = 1'b0;
    bus.ren_wa = '0;
    tick();
    tick();
    chk("rst_rdy", bus.cmt_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rel_we", bus.rel_we, 0);
    chk("rst_rel_wa", bus.rel_wa, 0);
    chk("rst_rel_wd", bus.rel_wd, 32'h7F);
    chk("rst_src_ra", bus.src_ra, 0);
    chk("rst_count", rel_count, 0);
    rst_n = 1'b1;
    chk("rdy_at_release", bus.cmt_rdy, 0);
    tick();
    chk("rdy_after_release", bus.cmt_rdy, 1);
    // single slot, matching producer
    setw(5, 3);
    send(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd5}, {6'd0, 6'd0, 6'd0, 6'd3});
    chk("t1_busy", busy, 1);
    chk("t1_rdy_low", bus.cmt_rdy, 0);
    chk("t1_src_ra", bus.src_ra, 5);
    chk("t1_no_we_read", bus.rel_we, 0);
    tick();
    chk("t1_rel_we", bus.rel_we, 1);
    chk("t1_rel_wa", bus.rel_wa, 5);
    chk("t1_rel_wd", bus.rel_wd, 32'h7F);
    tick();
    chk("t1_rdy_back", bus.cmt_rdy, 1);
    chk("t1_count", rel_count, 1);
    chk("t1_we_off", bus.rel_we, 0);
    // single slot, younger producer owns the entry
    setw(5, 7);
    send(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd5}, {6'd0, 6'd0, 6'd0, 6'd3});
    tick();
    chk("t2_no_we", bus.rel_we, 0);
    tick();
    chk("t2_count", rel_count, 1);
    chk("t2_rdy", bus.cmt_rdy, 1);
    // four slots, duplicate Rd=2, Rd=0 skipped
    setw(1, 8);
    setw(2, 10);
    send(4'b1111, 4'b1111, {12'd0, 12'd2, 12'd2, 12'd1}, {6'd11, 6'd10, 6'd9, 6'd8});
    chk("t3_ra_s0", bus.src_ra, 1);
    tick();
    chk("t3_we_s0", bus.rel_we, 1);
    chk("t3_wa_s0", bus.rel_wa, 1);
    tick();
    chk("t3_ra_s1", bus.src_ra, 2);
    tick();
    chk("t3_we_s1", bus.rel_we, 0);
    tick();
    chk("t3_ra_s2", bus.src_ra, 2);
    tick();
    chk("t3_we_s2", bus.rel_we, 1);
    chk("t3_wa_s2", bus.rel_wa, 2);
    chk("t3_busy_last", busy, 1);
    tick();
    chk("t3_rdy_6cyc", bus.cmt_rdy, 1);
    chk("t3_count", rel_count, 3);
    // rename write to the same register during READ
    setw(7, 4);
    send(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd7}, {6'd0, 6'd0, 6'd0, 6'd4});
    bus.ren_we = 1'b1;
    bus.ren_wa = 12'd7;
    ren_wd = 7'd20;
    tick();
    bus.ren_we = 1'b0;
    chk("t4a_stale_no_we", bus.rel_we, 0);
    tick();
    chk("t4a_count", rel_count, 3);
    // rename write to the same register during CMP
    setw(7, 4);
    send(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd7}, {6'd0, 6'd0, 6'd0, 6'd4});
    tick();
    chk("t4b_match_we", bus.rel_we, 1);
    bus.ren_we = 1'b1;
    bus.ren_wa = 12'd7;
    ren_wd = 7'd21;
    #1;
    chk("t4b_ren_no_we", bus.rel_we, 0);
    tick();
    bus.ren_we = 1'b0;
    chk("t4b_count", rel_count, 3);
    chk("t4b_tbl", tbl[7], 21);
    // branchmiss held three cycles during CMP of slot 1
    setw(8, 5);
    setw(9, 6);
    send(4'b0011, 4'b0011, {12'd0, 12'd0, 12'd9, 12'd8}, {6'd0, 6'd0, 6'd6, 6'd5});
    tick();
    chk("t5_we_s0", bus.rel_we, 1);
    tick();
    chk("t5_ra_s1", bus.src_ra, 9);
    tick();
    branchmiss = 1'b1;
    #1;
    chk("t5_bm_we0", bus.rel_we, 0);
    chk("t5_bm_rdy", bus.cmt_rdy, 0);
    tick();
    chk("t5_bm_we1", bus.rel_we, 0);
    chk("t5_bm_busy", busy, 1);
    tick();
    chk("t5_bm_we2", bus.rel_we, 0);
    tick();
    branchmiss = 1'b0;
    chk("t5_reread_ra", bus.src_ra, 9);
    chk("t5_reread_we", bus.rel_we, 0);
    tick();
    chk("t5_we_s1", bus.rel_we, 1);
    chk("t5_wa_s1", bus.rel_wa, 9);
    tick();
    chk("t5_count", rel_count, 5);
    chk("t5_rdy", bus.cmt_rdy, 1);
    // async reset in the middle of a bundle
    setw(3, 1);
    send(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd3}, {6'd0, 6'd0, 6'd0, 6'd1});
    tick();
    chk("t6_we_before", bus.rel_we, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we_drop", bus.rel_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", rel_count, 0);
    chk("t6_rdy", bus.cmt_rdy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_we_after", bus.rel_we, 0);
    chk("t6_tbl_kept", tbl[3], 1);
    tick();
    chk("t6_idle", busy, 0);
    chk("t6_count_after", rel_count, 0);
    // empty mask: rfw clear, and Rd=0 only
    send(4'b0001, 4'b0000, {12'd0, 12'd0, 12'd0, 12'd3}, {6'd0, 6'd0, 6'd0, 6'd1});
    chk("t7_norfw_busy", busy, 0);
    chk("t7_norfw_rdy", bus.cmt_rdy, 1);
    send(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd0}, {6'd0, 6'd0, 6'd0, 6'd1});
    chk("t7_rd0_busy", busy, 0);
    chk("t7_rd0_we", bus.rel_we, 0);
    chk("t7_count", rel_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
